// File: rtl/round_sticky_pipe.sv
// Two-stage round-and-sticky pipeline for multiplier mantissas with valid/ready flow
// control and a saturating count of inexact results delivered downstream.
module round_sticky_pipe #(
  parameter int IN_W  = 48,
  parameter int OUT_W = 24,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [IN_W-1:0]  i_in_mant,
  input  logic             i_in_sign,
  input  logic [1:0]       i_in_rm,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [OUT_W-1:0] o_out_mant,
  output logic             o_out_carry,
  output logic             o_out_sticky,
  output logic             o_out_inexact,
  input  logic             i_cnt_clr,
  output logic [CNT_W-1:0] o_inexact_cnt
);

  localparam int LO_W = IN_W - OUT_W - 1;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  logic             r_s1_valid;
  logic [OUT_W-1:0] r_s1_keep;
  logic             r_s1_guard;
  logic             r_s1_sticky;
  logic             r_s1_sign;
  logic [1:0]       r_s1_rm;

  logic             r_s2_valid;
  logic [OUT_W-1:0] r_s2_mant;
  logic             r_s2_carry;
  logic             r_s2_sticky;
  logic             r_s2_inexact;

  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_s2_adv;
  logic             w_xfer;
  logic [OUT_W-1:0] w_keep;
  logic             w_guard;
  logic             w_sticky;
  logic             w_inc;
  logic [OUT_W:0]   w_sum;
  logic             w_carry;
  logic [OUT_W-1:0] w_mant;

  assign w_keep   = i_in_mant[IN_W-1 -: OUT_W];
  assign w_guard  = i_in_mant[LO_W];
  assign w_sticky = |i_in_mant[LO_W-1:0];

  // Stage 2 frees up when empty or draining; stage 1 can then always accept.
  assign w_s2_adv   = ~r_s2_valid | i_out_ready;
  assign o_in_ready = ~r_s1_valid | w_s2_adv;
  assign w_accept   = i_in_valid & o_in_ready;
  assign w_xfer     = r_s2_valid & i_out_ready;

  always_comb begin
    w_inc = 1'b0;
    case (r_s1_rm)
      RM_RNE:  w_inc = r_s1_guard & (r_s1_sticky | r_s1_keep[0]);
      RM_RTZ:  w_inc = 1'b0;
      RM_RUP:  w_inc = (r_s1_guard | r_s1_sticky) & ~r_s1_sign;
      RM_RDN:  w_inc = (r_s1_guard | r_s1_sticky) & r_s1_sign;
      default: w_inc = 1'b0;
    endcase
  end

  assign w_sum   = {1'b0, r_s1_keep} + {{OUT_W{1'b0}}, w_inc};
  assign w_carry = w_sum[OUT_W];
  // On overflow the sum is exactly 2^OUT_W, so the shifted form is the renormalised mantissa.
  assign w_mant  = w_carry ? w_sum[OUT_W:1] : w_sum[OUT_W-1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_keep   <= '0;
      r_s1_guard  <= 1'b0;
      r_s1_sticky <= 1'b0;
      r_s1_sign   <= 1'b0;
      r_s1_rm     <= 2'b00;
    end else if (o_in_ready) begin
      r_s1_valid <= i_in_valid;
      if (i_in_valid) begin
        r_s1_keep   <= w_keep;
        r_s1_guard  <= w_guard;
        r_s1_sticky <= w_sticky;
        r_s1_sign   <= i_in_sign;
        r_s1_rm     <= i_in_rm;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_valid   <= 1'b0;
      r_s2_mant    <= '0;
      r_s2_carry   <= 1'b0;
      r_s2_sticky  <= 1'b0;
      r_s2_inexact <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_mant    <= w_mant;
        r_s2_carry   <= w_carry;
        r_s2_sticky  <= r_s1_sticky;
        r_s2_inexact <= r_s1_guard | r_s1_sticky;
      end
    end
  end

  // Clear has priority over a counted transfer in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_cnt_clr) begin
      r_cnt <= '0;
    end else if (w_xfer && r_s2_inexact && !(&r_cnt)) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_out_valid   = r_s2_valid;
  assign o_out_mant    = r_s2_mant;
  assign o_out_carry   = r_s2_carry;
  assign o_out_sticky  = r_s2_sticky;
  assign o_out_inexact = r_s2_inexact;
  assign o_inexact_cnt = r_cnt;

endmodule

// File: tb/tb_round_sticky_pipe.sv
// Bench for round_sticky_pipe: directed vectors with literal expectations plus an
// arithmetic rounding model and scoreboard checked on every delivered result.
module tb_round_sticky_pipe;

  localparam int IN_W  = 48;
  localparam int OUT_W = 24;
  localparam int CNT_W = 3;
  localparam int LSH   = IN_W - OUT_W;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_mant;
  logic             in_sign;
  logic [1:0]       in_rm;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_mant;
  logic             out_carry;
  logic             out_sticky;
  logic             out_inexact;
  logic             cnt_clr;
  logic [CNT_W-1:0] inexact_cnt;

  always #5 clk = ~clk;

  round_sticky_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_in_valid    (in_valid),
    .o_in_ready    (in_ready),
    .i_in_mant     (in_mant),
    .i_in_sign     (in_sign),
    .i_in_rm       (in_rm),
    .o_out_valid   (out_valid),
    .i_out_ready   (out_ready),
    .o_out_mant    (out_mant),
    .o_out_carry   (out_carry),
    .o_out_sticky  (out_sticky),
    .o_out_inexact (out_inexact),
    .i_cnt_clr     (cnt_clr),
    .o_inexact_cnt (inexact_cnt)
  );

  typedef struct packed {
    logic [OUT_W-1:0] mant;
    logic             carry;
    logic             sticky;
    logic             inexact;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  int   model_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Rounding from the numeric value: compare the discarded remainder against one half ulp.
  function automatic exp_t model(input logic [IN_W-1:0] m, input logic s, input logic [1:0] rm);
    longint unsigned keep, rem, half, sum;
    logic up;
    exp_t r;
    keep = 64'(m) >> LSH;
    rem  = 64'(m) & ((64'd1 << LSH) - 1);
    half = 64'd1 << (LSH - 1);
    case (rm)
      2'b00:   up = (rem > half) || (rem == half && (keep % 2) == 1);
      2'b01:   up = 1'b0;
      2'b10:   up = (rem != 0) && !s;
      default: up = (rem != 0) && s;
    endcase
    sum       = keep + (up ? 64'd1 : 64'd0);
    r.carry   = (sum >> OUT_W) != 0;
    r.mant    = r.carry ? OUT_W'(sum >> 1) : OUT_W'(sum);
    r.sticky  = (rem % half) != 0;
    r.inexact = rem != 0;
    return r;
  endfunction

  exp_t held;
  exp_t e;
  logic stall_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      model_cnt  = 0;
      stall_prev = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_fields", {out_mant, out_carry, out_sticky, out_inexact}, 0);
      chk("rst_cnt", inexact_cnt, 0);
    end else begin
      chk("cnt_model", inexact_cnt, model_cnt);
      if (stall_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_fields", {out_mant, out_carry, out_sticky, out_inexact}, held);
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result actual=%0h expected=none", out_mant);
        end else begin
          e = q.pop_front();
          chk("sb_mant", out_mant, e.mant);
          chk("sb_carry", out_carry, e.carry);
          chk("sb_sticky", out_sticky, e.sticky);
          chk("sb_inexact", out_inexact, e.inexact);
          if (cnt_clr) model_cnt = 0;
          else if (e.inexact && model_cnt < MAXC) model_cnt++;
        end
      end else if (cnt_clr) begin
        model_cnt = 0;
      end
      stall_prev = out_valid && !out_ready;
      if (stall_prev) held = {out_mant, out_carry, out_sticky, out_inexact};
      if (in_valid && in_ready) q.push_back(model(in_mant, in_sign, in_rm));
    end
  end

  // Called in the phase just after a rising edge; returns one phase after acceptance.
  task automatic send(input logic [IN_W-1:0] m, input logic s, input logic [1:0] rm);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_mant  = m;
    in_sign  = s;
    in_rm    = rm;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_one(input string name, input logic [IN_W-1:0] m, input logic s,
                         input logic [1:0] rm, input logic [OUT_W-1:0] x_mant,
                         input logic x_carry, input logic x_sticky, input logic x_inexact);
    out_ready = 1'b1;
    send(m, s, rm);
    @(negedge clk);
    chk({name, "_lat1"}, out_valid, 0);
    @(negedge clk);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_mant"}, out_mant, x_mant);
    chk({name, "_carry"}, out_carry, x_carry);
    chk({name, "_sticky"}, out_sticky, x_sticky);
    chk({name, "_inexact"}, out_inexact, x_inexact);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) break;
    end
    chk("drain_empty", q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t pin;
    logic [IN_W-1:0] ops [3];
    logic [63:0] rnd;
    int idx, sent;
    logic acc;

    rst_n = 1'b0; in_valid = 1'b0; in_mant = '0; in_sign = 1'b0; in_rm = 2'b00;
    out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);
    chk("rel_out_valid", out_valid, 0);
    @(posedge clk); #1;

    pin = model(48'h800001_800000, 1'b0, 2'b00);
    chk("pin_rne_odd", pin, {24'h800002, 1'b0, 1'b0, 1'b1});
    pin = model(48'h800000_800000, 1'b0, 2'b00);
    chk("pin_rne_tie", pin, {24'h800000, 1'b0, 1'b0, 1'b1});
    pin = model(48'hFFFFFF_C00000, 1'b0, 2'b00);
    chk("pin_carry", pin, {24'h800000, 1'b1, 1'b1, 1'b1});
    pin = model(48'h800000_000002, 1'b0, 2'b10);
    chk("pin_rup", pin, {24'h800001, 1'b0, 1'b1, 1'b1});

    run_one("zero",     48'h000000_000000, 1'b0, 2'b00, 24'h000000, 1'b0, 1'b0, 1'b0);
    run_one("rne_odd",  48'h800001_800000, 1'b0, 2'b00, 24'h800002, 1'b0, 1'b0, 1'b1);
    run_one("rne_tie",  48'h800000_800000, 1'b0, 2'b00, 24'h800000, 1'b0, 1'b0, 1'b1);
    run_one("stk_rne",  48'h800000_000002, 1'b0, 2'b00, 24'h800000, 1'b0, 1'b1, 1'b1);
    run_one("stk_rup",  48'h800000_000002, 1'b0, 2'b10, 24'h800001, 1'b0, 1'b1, 1'b1);
    run_one("stk_rdn",  48'h800000_000002, 1'b0, 2'b11, 24'h800000, 1'b0, 1'b1, 1'b1);
    run_one("stk_rtz",  48'h800000_000002, 1'b0, 2'b01, 24'h800000, 1'b0, 1'b1, 1'b1);
    run_one("carry",    48'hFFFFFF_C00000, 1'b0, 2'b00, 24'h800000, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    chk("cnt_seven", inexact_cnt, 7);
    @(posedge clk); #1;
    run_one("rdn_neg",  48'h123456_FFFFFF, 1'b1, 2'b11, 24'h123457, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("cnt_saturated", inexact_cnt, 7);
    @(posedge clk); #1;

    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("cnt_cleared", inexact_cnt, 0);
    @(posedge clk); #1;
    run_one("c1", 48'h400000_000001, 1'b0, 2'b01, 24'h400000, 1'b0, 1'b1, 1'b1);
    run_one("c2", 48'h400000_400000, 1'b0, 2'b00, 24'h400000, 1'b0, 1'b1, 1'b1);
    run_one("c3", 48'h400001_900000, 1'b0, 2'b00, 24'h400002, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("cnt_three", inexact_cnt, 3);
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(48'h400003_000010, 1'b0, 2'b10);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("c4_valid", out_valid, 1);
    @(posedge clk); #1;
    cnt_clr = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    @(negedge clk);
    chk("cnt_clear_wins", inexact_cnt, 0);
    chk("c4_delivered", q.size(), 0);
    @(posedge clk); #1;

    ops[0] = 48'h111111_800000;
    ops[1] = 48'hABCDEF_C00001;
    ops[2] = 48'hFFFFFF_FFFFFF;
    idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = (idx < 3);
      in_mant  = ops[idx < 3 ? idx : 2];
      in_sign  = 1'b0;
      in_rm    = 2'b00;
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("bp_accepts", idx, 2);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 3; c++) begin
      in_valid = 1'b1;
      in_mant  = ops[idx];
      @(negedge clk);
      if (in_ready) idx++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_all_accepted", idx, 3);
    drain();

    sent = 0;
    acc = 1'b0;
    for (int c = 0; c < 3000 && sent < 200; c++) begin
      if (acc) in_valid = 1'b0;
      out_ready = ($urandom_range(3) != 0);
      if (!in_valid && $urandom_range(3) != 0) begin
        rnd = {$urandom(), $urandom()};
        in_mant = rnd[IN_W-1:0];
        case ($urandom_range(3))
          0: in_mant[LSH-1:0] = 24'h800000;
          1: in_mant[LSH-1:0] = 24'h000000;
          default: ;
        endcase
        if ($urandom_range(7) == 0) in_mant[IN_W-1:LSH] = 24'hFFFFFF;
        in_sign  = 1'($urandom_range(1));
        in_rm    = 2'($urandom_range(3));
        in_valid = 1'b1;
      end
      cnt_clr = ($urandom_range(31) == 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    cnt_clr  = 1'b0;
    chk("rand_sent", sent, 200);
    drain();

    run_one("pre_rst", 48'h200000_300000, 1'b0, 2'b10, 24'h200001, 1'b0, 1'b1, 1'b1);
    out_ready = 1'b0;
    send(48'h300000_000001, 1'b0, 2'b00);
    send(48'h300001_800000, 1'b0, 2'b00);
    @(negedge clk);
    chk("mid_pre_valid", out_valid, 1);
    chk("mid_pre_cnt_nz", inexact_cnt != 0, 1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cnt", inexact_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("no_ghost", out_valid, 0);
    end
    @(posedge clk); #1;
    run_one("post_rst", 48'h7FFFFF_800001, 1'b0, 2'b00, 24'h800000, 1'b0, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
